// File: rtl/traffic_monitor_8.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_monitor_8
//  Description : Passive safety monitor for a two-direction (North/East)
//                six-lamp traffic-light controller. Decodes lamp patterns,
//                checks patterns and phase transitions, latches the first
//                violation as a sticky fault code and counts completed
//                intersection cycles.
//                Optional yellow-dwell check (fault code 4) is compiled in
//                when TRAFFIC_MONITOR_8_DWELL_CHECK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_monitor_8 #(
    parameter int MIN_Y = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_NR,
    input  logic             in_NG,
    input  logic             in_NY,
    input  logic             in_ER,
    input  logic             in_EG,
    input  logic             in_EY,
    input  logic             in_EN,
    input  logic             fault_clr,
    output logic             armed,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] cycles
);

    // Phase encoding of a single direction
    localparam logic [1:0] c_PH_RED     = 2'd0;
    localparam logic [1:0] c_PH_GREEN   = 2'd1;
    localparam logic [1:0] c_PH_YELLOW  = 2'd2;
    localparam logic [1:0] c_PH_ILLEGAL = 2'd3;

    localparam logic [2:0] c_CODE_NONE     = 3'd0;
    localparam logic [2:0] c_CODE_ILLEGAL  = 3'd1;
    localparam logic [2:0] c_CODE_CONFLICT = 3'd2;
    localparam logic [2:0] c_CODE_SEQUENCE = 3'd3;
    localparam logic [2:0] c_CODE_DWELL    = 3'd4;

    localparam logic [CNT_W-1:0] c_CYC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // One-hot lamp triple {R,G,Y} to phase; anything else is ILLEGAL
    function automatic logic [1:0] f_decode(input logic r, input logic g, input logic y);
        logic [1:0] ph;
        case ({r, g, y})
            3'b100:  ph = c_PH_RED;
            3'b010:  ph = c_PH_GREEN;
            3'b001:  ph = c_PH_YELLOW;
            default: ph = c_PH_ILLEGAL;
        endcase
        return ph;
    endfunction

    // Allowed phase steps: hold, RED->GREEN, GREEN->YELLOW, YELLOW->RED
    function automatic logic f_legal_step(input logic [1:0] prv, input logic [1:0] cur);
        return (prv == cur) ||
               ((prv == c_PH_RED)    && (cur == c_PH_GREEN))  ||
               ((prv == c_PH_GREEN)  && (cur == c_PH_YELLOW)) ||
               ((prv == c_PH_YELLOW) && (cur == c_PH_RED));
    endfunction

    logic [1:0]       w_dec_n;
    logic [1:0]       w_dec_e;
    logic [1:0]       r_cur_n;
    logic [1:0]       r_cur_e;
    logic [1:0]       r_prev_n;
    logic [1:0]       r_prev_e;
    logic             r_armed;
    logic             r_fault;
    logic [2:0]       r_fault_code;
    logic [CNT_W-1:0] r_cycles;

    logic             w_chk_illegal;
    logic             w_chk_conflict;
    logic             w_chk_sequence;
    logic             w_chk_dwell;
    logic             w_fire;
    logic [2:0]       w_code;
    logic             w_cycle_done;

    assign w_dec_n = f_decode(in_NR, in_NG, in_NY);
    assign w_dec_e = f_decode(in_ER, in_EG, in_EY);

    // Input stage: decoded phases into cur, previous cur into prev
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_n  <= c_PH_RED;
            r_cur_e  <= c_PH_RED;
            r_prev_n <= c_PH_RED;
            r_prev_e <= c_PH_RED;
        end else begin
            r_cur_n  <= w_dec_n;
            r_cur_e  <= w_dec_e;
            r_prev_n <= r_cur_n;
            r_prev_e <= r_cur_e;
        end
    end

`ifdef TRAFFIC_MONITOR_8_DWELL_CHECK_EN
    localparam logic [5:0] c_MIN_Y = 6'(MIN_Y);

    logic [4:0] r_dwell_n;
    logic [4:0] r_dwell_e;

    // Clear on the edge that enters YELLOW; count ticks only on edges where
    // the direction is YELLOW both before and after, so neither the entry
    // nor the exit edge contributes a tick. Saturates at 31.
    function automatic logic [4:0] f_dwell_next(input logic [4:0] cnt,
                                                input logic [1:0] cur,
                                                input logic [1:0] dec,
                                                input logic       tick);
        logic [4:0] nxt;
        nxt = cnt;
        if ((dec == c_PH_YELLOW) && (cur != c_PH_YELLOW)) begin
            nxt = 5'd0;
        end else if ((dec == c_PH_YELLOW) && tick && (cnt != 5'd31)) begin
            nxt = cnt + 5'd1;
        end
        return nxt;
    endfunction

    // Per-direction yellow dwell counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell_n <= 5'd0;
            r_dwell_e <= 5'd0;
        end else begin
            r_dwell_n <= f_dwell_next(r_dwell_n, r_cur_n, w_dec_n, in_EN);
            r_dwell_e <= f_dwell_next(r_dwell_e, r_cur_e, w_dec_e, in_EN);
        end
    end

    assign w_chk_dwell =
        ((r_prev_n == c_PH_YELLOW) && (r_cur_n == c_PH_RED) && ({1'b0, r_dwell_n} < c_MIN_Y)) ||
        ((r_prev_e == c_PH_YELLOW) && (r_cur_e == c_PH_RED) && ({1'b0, r_dwell_e} < c_MIN_Y));
`else
    // The tick only feeds the dwell counters, which are absent here
    logic w_unused_en;
    assign w_unused_en = in_EN;
    assign w_chk_dwell = 1'b0;
`endif

    // Rule evaluation on the registered phases; lowest code has priority
    always_comb begin
        w_chk_illegal  = (r_cur_n == c_PH_ILLEGAL) || (r_cur_e == c_PH_ILLEGAL);
        w_chk_conflict = (r_cur_n != c_PH_RED) && (r_cur_e != c_PH_RED);
        w_chk_sequence = !f_legal_step(r_prev_n, r_cur_n) || !f_legal_step(r_prev_e, r_cur_e);
        w_code         = c_CODE_NONE;
        if (w_chk_illegal) begin
            w_code = c_CODE_ILLEGAL;
        end else if (w_chk_conflict) begin
            w_code = c_CODE_CONFLICT;
        end else if (w_chk_sequence) begin
            w_code = c_CODE_SEQUENCE;
        end else if (w_chk_dwell) begin
            w_code = c_CODE_DWELL;
        end
        w_fire       = r_armed && (w_code != c_CODE_NONE);
        w_cycle_done = r_armed && (r_prev_n == c_PH_RED) && (r_cur_n == c_PH_GREEN);
    end

    // Arm once both directions have been seen RED together; sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (!r_armed && (r_cur_n == c_PH_RED) && (r_cur_e == c_PH_RED)) begin
            r_armed <= 1'b1;
        end
    end

    // Sticky fault latch: first violation wins, a clear in the same cycle
    // as a new violation still captures that violation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault      <= 1'b0;
            r_fault_code <= c_CODE_NONE;
        end else if (w_fire && (!r_fault || fault_clr)) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_code;
        end else if (fault_clr) begin
            r_fault      <= 1'b0;
            r_fault_code <= c_CODE_NONE;
        end
    end

    // Completed-cycle counter: North entering GREEN from RED; wraps, ignores faults
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= '0;
        end else if (w_cycle_done) begin
            r_cycles <= r_cycles + c_CYC_ONE;
        end
    end

    assign armed      = r_armed;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign cycles     = r_cycles;

endmodule
`default_nettype wire

// File: doc/traffic_monitor_8.md
# traffic_monitor_8

Passive safety monitor for the six-lamp, two-direction (North/East) traffic-light controller. It samples the six lamp outputs and the shared tick enable, and checks every lamp pattern and phase transition against the legal intersection sequence. The first violation is latched into a sticky fault code. It also counts completed intersection cycles. The block sits beside the controller on the same clock, reads its lamp outputs, and never drives the controller.

## Interface
Parameters:
- MIN_Y, 8: minimum number of tick-qualified cycles a direction must stay YELLOW.
- CNT_W, 8: width of the completed-cycle counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- in_NR, in_NG, in_NY  in  1 each  North lamps (red, green, yellow).
- in_ER, in_EG, in_EY  in  1 each  East lamps (red, green, yellow).
- in_EN  in  1  time-base tick; the same enable that drives the controller's counter.
- fault_clr  in  1  clears the latched fault.
- armed  out  1  monitor is actively checking.
- fault  out  1  sticky fault flag.
- fault_code  out  3  code of the first fault since the last clear.
- cycles  out  CNT_W  count of completed intersection cycles.

## Operation
- Lamp decode per direction, as {R,G,Y}:
  - 100 = RED, 010 = GREEN, 001 = YELLOW.
  - Any other pattern = ILLEGAL.
- Input stage: each edge, the decoded phases load into cur_N/cur_E and the previous cur values move into prev_N/prev_E.
- Arming:
  - After rst, armed=0 and no checks run.
  - armed sets on the edge after the first cycle in which cur_N = cur_E = RED.
  - armed stays set until rst.
- Checks are evaluated each cycle while armed. When several fire in the same cycle, the lowest code wins:
  - 1 ILLEGAL: either cur phase is ILLEGAL.
  - 2 CONFLICT: cur_N ≠ RED and cur_E ≠ RED.
  - 3 SEQUENCE: a transition other than RED→GREEN, GREEN→YELLOW, YELLOW→RED, or no change.
  - 4 DWELL: a YELLOW→RED transition with that direction's dwell count < MIN_Y. This check exists only when compiled in (see Configuration).
- Fault latch:
  - When no fault is held and any check fires, fault←1 and fault_code←code.
  - Later violations do not overwrite a held fault.
  - fault_clr clears fault and fault_code to 0.
  - If fault_clr and a new violation occur in the same cycle, the new violation is latched.
- Dwell counters: one per direction, 5 bits.
  - Cleared to 0 on entry to YELLOW.
  - While YELLOW, increment on cycles with in_EN=1.
  - Saturate at 31.
- cycles:
  - Increments when cur_N enters GREEN from RED while armed.
  - Wraps from 2^CNT_W−1 to 0.
  - Keeps counting after a fault.

## Timing
- Reset values: armed=0, fault=0, fault_code=0, cycles=0, cur/prev phases=RED, dwell counters=0.
- Latency: lamps present at edge N are loaded into cur at edge N; fault and fault_code update at edge N+1. That is 2 edges from input to flag.
- cycles updates on the same edge as fault, also 2 edges after the input.
- rst mid-operation: all state returns to reset values on that edge, and the monitor must re-arm before checking again.
- A held fault persists across arbitrary lamp activity until fault_clr or rst.
- Dwell boundary: exactly MIN_Y tick cycles in YELLOW passes; MIN_Y−1 fails.
- Ticks present on the transition edge itself are not counted.

## Configuration
- Macro: TRAFFIC_MONITOR_8_DWELL_CHECK_EN.
- Defined: dwell counters and fault code 4 are present, as described above.
- Undefined:
  - Dwell counters are removed.
  - Code 4 is never produced.
  - A too-short yellow is not flagged.
  - All other behaviour is identical.

## Test plan
- rst, then lamps N=100, E=100 for 1 cycle → armed=1 two edges later; fault=0, cycles=0.
- Legal sequence with 8 ticks in each yellow, run 3 full cycles → cycles=3, fault=0.
- While armed, N=010 and E=010 simultaneously → fault=1, fault_code=2 two edges later; a later ILLEGAL pattern leaves the code at 2.
- N goes GREEN→RED, skipping yellow → fault_code=3; assert fault_clr → fault=0, fault_code=0 next edge.
- N yellow held for 7 ticks, then RED:
  - With the macro defined → fault_code=4.
  - Without the macro → fault=0.
  - Repeat with 8 ticks → fault=0.
- Pattern 110 on N before arming → no fault; same pattern after arming → fault_code=1; fault_clr together with a new conflict in the same cycle → fault_code=2.
